// File: rtl/tick_generator.sv
// tick_generator: programmable period/width pulse generator with
// free-running, one-shot and burst modes plus start/busy/done handshake.
module tick_generator #(
  parameter int unsigned CNT_W          = 32,
  parameter int unsigned PW_W           = 8,
  parameter int unsigned BURST_W        = 8,
  parameter int unsigned DEFAULT_PERIOD = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clear,
  input  logic               ena,
  input  logic               load,
  input  logic               start,
  input  logic [CNT_W-1:0]   period_i,
  input  logic [PW_W-1:0]    width_i,
  input  logic [1:0]         mode_i,
  input  logic [BURST_W-1:0] burst_i,
  output logic               out,
  output logic               busy,
  output logic               done,
  output logic [CNT_W-1:0]   count_o
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  typedef enum logic [1:0] {
    MODE_FREE     = 2'b00,
    MODE_ONESHOT  = 2'b01,
    MODE_BURST    = 2'b10,
    MODE_FREE_ALT = 2'b11
  } mode_t;

  state_t             state;
  mode_t              mode_r;
  mode_t              new_mode;
  logic [CNT_W-1:0]   period_r;
  logic [PW_W-1:0]    width_r;
  logic [BURST_W-1:0] burst_r;
  logic [CNT_W-1:0]   count;
  logic [PW_W-1:0]    pw_cnt;
  logic [BURST_W-1:0] pulses_left;

  logic [CNT_W-1:0]   period_eff;
  logic [PW_W-1:0]    width_nz;
  logic [CNT_W-1:0]   width_eff;
  logic [PW_W-1:0]    pw_load;
  logic [BURST_W-1:0] burst_eff;
  logic               seq_mode;
  logic               new_free;
  logic               terminal;

  // Clamped effective configuration and terminal-count decode
  always_comb begin
    period_eff = (period_r == '0) ? CNT_W'(1) : period_r;
    width_nz   = (width_r == '0) ? PW_W'(1) : width_r;
    if (CNT_W'(width_nz) > period_eff) begin
      width_eff = period_eff;
    end else begin
      width_eff = CNT_W'(width_nz);
    end
    pw_load   = PW_W'(width_eff - CNT_W'(1));
    if (mode_r == MODE_ONESHOT || burst_r == '0) begin
      burst_eff = BURST_W'(1);
    end else begin
      burst_eff = burst_r;
    end
    seq_mode  = (mode_r == MODE_ONESHOT) || (mode_r == MODE_BURST);
    new_mode  = mode_t'(mode_i);
    new_free  = !((new_mode == MODE_ONESHOT) || (new_mode == MODE_BURST));
    terminal  = (count == period_eff - CNT_W'(1));
  end

  // Config, counters, pulse timing and run/idle control
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      period_r    <= CNT_W'(DEFAULT_PERIOD);
      width_r     <= PW_W'(1);
      mode_r      <= MODE_FREE;
      burst_r     <= BURST_W'(1);
      count       <= '0;
      pw_cnt      <= '0;
      pulses_left <= '0;
      out         <= 1'b0;
      done        <= 1'b0;
      state       <= RUN;
    end else begin
      done <= 1'b0;
      if (clear) begin
        count       <= '0;
        pw_cnt      <= '0;
        pulses_left <= '0;
        out         <= 1'b0;
        state       <= seq_mode ? IDLE : RUN;
      end else if (load) begin
        period_r    <= period_i;
        width_r     <= width_i;
        mode_r      <= new_mode;
        burst_r     <= burst_i;
        count       <= '0;
        pw_cnt      <= '0;
        pulses_left <= '0;
        out         <= 1'b0;
        state       <= new_free ? RUN : IDLE;
      end else if (start && state == IDLE && seq_mode) begin
        state       <= RUN;
        count       <= '0;
        pulses_left <= burst_eff;
      end else if (state == RUN && ena) begin
        count <= terminal ? '0 : count + CNT_W'(1);
        // A new pulse start wins over expiry of the current one, so
        // width == period keeps out high across back-to-back pulses.
        if (terminal && (!seq_mode || pulses_left != '0)) begin
          out    <= 1'b1;
          pw_cnt <= pw_load;
          if (seq_mode) begin
            pulses_left <= pulses_left - BURST_W'(1);
          end
        end else if (out) begin
          if (pw_cnt == '0) begin
            out <= 1'b0;
            if (seq_mode && pulses_left == '0) begin
              state <= IDLE;
              count <= '0;
              done  <= 1'b1;
            end
          end else begin
            pw_cnt <= pw_cnt - PW_W'(1);
          end
        end
      end
    end
  end

  assign busy    = (state == RUN);
  assign count_o = count;

endmodule

// File: tb/tb_tick_generator.sv
// Scoreboard bench for tick_generator: a reference model predicts
// out/done/busy/count_o per clock, expectations are queued before each
// edge and popped/compared after it.
module tb_tick_generator;

  logic        clk;
  logic        rst_n;
  logic        clear;
  logic        ena;
  logic        load;
  logic        start;
  logic [31:0] period_i;
  logic [7:0]  width_i;
  logic [1:0]  mode_i;
  logic [7:0]  burst_i;
  logic        out;
  logic        busy;
  logic        done;
  logic [31:0] count_o;

  tick_generator #(
    .CNT_W(32),
    .PW_W(8),
    .BURST_W(8),
    .DEFAULT_PERIOD(5)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .clear(clear),
    .ena(ena),
    .load(load),
    .start(start),
    .period_i(period_i),
    .width_i(width_i),
    .mode_i(mode_i),
    .burst_i(burst_i),
    .out(out),
    .busy(busy),
    .done(done),
    .count_o(count_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        out;
    logic        done;
    logic        busy;
    logic [31:0] count;
  } exp_t;

  exp_t sb_q[$];

  int n_tests = 0;
  int n_fail  = 0;
  int done_seen = 0;

  // reference model state
  int unsigned m_period, m_width, m_mode, m_burst;
  int unsigned m_cnt;
  int          m_hi;
  int          m_rem;
  bit          m_run;
  bit          m_done;

  task automatic check(input string tag, input longint unsigned obs, input longint unsigned exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_period = 5; m_width = 1; m_mode = 0; m_burst = 1;
    m_cnt = 0; m_hi = 0; m_rem = 0; m_run = 1'b1; m_done = 1'b0;
  endtask

  function automatic bit is_free(input int unsigned md);
    return (md == 0) || (md == 3);
  endfunction

  task automatic model_step();
    int unsigned pe, we, be, nxt;
    m_done = 1'b0;
    if (clear) begin
      m_cnt = 0; m_hi = 0; m_rem = 0; m_run = is_free(m_mode);
    end else if (load) begin
      m_period = period_i; m_width = width_i; m_mode = mode_i; m_burst = burst_i;
      m_cnt = 0; m_hi = 0; m_rem = 0; m_run = is_free(m_mode);
    end else begin
      pe = (m_period == 0) ? 1 : m_period;
      we = (m_width == 0) ? 1 : m_width;
      if (we > pe) we = pe;
      be = (m_mode == 1 || m_burst == 0) ? 1 : m_burst;
      if (start && !m_run && !is_free(m_mode)) begin
        m_run = 1'b1; m_cnt = 0; m_hi = 0; m_rem = int'(be);
      end else if (m_run && ena) begin
        nxt = (m_cnt + 1) % pe;
        if (nxt == 0 && (is_free(m_mode) || m_rem > 0)) begin
          m_hi = int'(we);
          if (!is_free(m_mode)) m_rem--;
        end else if (m_hi > 0) begin
          m_hi--;
          if (m_hi == 0 && !is_free(m_mode) && m_rem == 0) begin
            m_run = 1'b0; nxt = 0; m_done = 1'b1;
          end
        end
        m_cnt = nxt;
      end
    end
  endtask

  // predict, push, clock, pop, compare
  task automatic cycle();
    exp_t e;
    model_step();
    e.out = (m_hi > 0); e.done = m_done; e.busy = m_run; e.count = m_cnt;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    if (done) done_seen++;
    if (sb_q.size() == 0) begin
      check("sb_empty", 1, 0);
    end else begin
      e = sb_q.pop_front();
      check("out", out, e.out);
      check("done", done, e.done);
      check("busy", busy, e.busy);
      check("count_o", count_o, e.count);
    end
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic do_load(input int unsigned p, input int unsigned w, input int unsigned md, input int unsigned b);
    period_i = p; width_i = w[7:0]; mode_i = md[1:0]; burst_i = b[7:0];
    load = 1'b1;
    cycle();
    load = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; clear = 1'b0; ena = 1'b0; load = 1'b0; start = 1'b0;
    period_i = '0; width_i = '0; mode_i = '0; burst_i = '0;
    model_reset();
    #12;
    check("rst_out", out, 0);
    check("rst_done", done, 0);
    check("rst_busy", busy, 1);
    check("rst_count", count_o, 0);
    rst_n = 1'b1;
    ena = 1'b1;

    // default free-run: period 5, width 1
    cycles(22);

    // width 3 / period 8 with ena toggling every cycle
    do_load(8, 3, 0, 1);
    for (int i = 0; i < 48; i++) begin
      ena = (i % 2 == 0);
      cycle();
    end
    ena = 1'b1;

    // burst of 3, second start during RUN ignored
    do_load(4, 2, 2, 3);
    check("burst_idle_busy", busy, 0);
    done_seen = 0;
    start = 1'b1; cycle(); start = 1'b0;
    cycles(6);
    start = 1'b1; cycle(); start = 1'b0;
    cycles(12);
    check("burst_done_once", done_seen, 1);
    check("burst_end_out", out, 0);
    check("burst_end_busy", busy, 0);

    // clamps: period 0 / width 0 free-run, then one-shot width > period
    do_load(0, 0, 0, 0);
    cycles(6);
    do_load(3, 9, 1, 5);
    start = 1'b1; cycle(); start = 1'b0;
    cycles(10);

    // load with start while idle in burst mode -> nothing starts
    do_load(4, 2, 2, 3);
    load = 1'b1; start = 1'b1; cycle(); load = 1'b0; start = 1'b0;
    cycles(6);
    check("ld_start_busy", busy, 0);

    // clear mid-burst aborts without done
    start = 1'b1; cycle(); start = 1'b0;
    cycles(5);
    done_seen = 0;
    clear = 1'b1; cycle(); clear = 1'b0;
    cycles(8);
    check("clear_no_done", done_seen, 0);
    check("clear_busy", busy, 0);

    // random ena in free-run mode 3
    do_load(6, 2, 3, 0);
    for (int i = 0; i < 30; i++) begin
      ena = ($urandom_range(0, 3) != 0);
      cycle();
    end
    ena = 1'b1;

    // async reset while out is high
    do_load(6, 4, 0, 1);
    cycles(7);
    check("pre_rst_out", out, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_out", out, 0);
    check("arst_done", done, 0);
    check("arst_count", count_o, 0);
    check("arst_busy", busy, 1);
    model_reset();
    sb_q.delete();
    #2;
    rst_n = 1'b1;
    // defaults restored: pulses every 5 cycles again
    cycles(16);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
